// File: rtl/chrono_ctrl_pkg.sv
// Shared definitions for the stopwatch/countdown sequencer: state encodings and
// default timing parameters.
package chrono_ctrl_pkg;

   typedef enum logic [2:0] {
      WStop = 3'b000,
      WRun  = 3'b001,
      WLap  = 3'b010,
      CSet  = 3'b011,
      CStop = 3'b100,
      CRun  = 3'b101,
      CLap  = 3'b110,
      CDone = 3'b111
   } state_e;

   localparam int unsigned AlarmSecDefault  = 10;
   localparam int unsigned HoldTicksDefault = 5;

   function automatic logic is_lap(state_e s);
      return (s == WLap) || (s == CLap);
   endfunction

endpackage

// File: rtl/chrono_ctrl_if.sv
// Button/tick/status inputs and sequencer outputs of chrono_ctrl; master drives the
// events, slave is the sequencer.
interface chrono_ctrl_if;
   import chrono_ctrl_pkg::*;

   logic   sec_tick;
   logic   rpt_tick;
   logic   btn1_p;
   logic   btn2_p;
   logic   btn1_lvl;
   logic   btn2_lvl;
   logic   mode;
   logic   set;
   logic   cnt_zero;
   state_e state;
   logic   inc_en;
   logic   dec_en;
   logic   sethr_en;
   logic   setmin_en;
   logic   clr;
   logic   freeze;
   logic   alarm;

   modport master (
      output sec_tick, rpt_tick, btn1_p, btn2_p, btn1_lvl, btn2_lvl, mode, set, cnt_zero,
      input  state, inc_en, dec_en, sethr_en, setmin_en, clr, freeze, alarm
   );

   modport slave (
      input  sec_tick, rpt_tick, btn1_p, btn2_p, btn1_lvl, btn2_lvl, mode, set, cnt_zero,
      output state, inc_en, dec_en, sethr_en, setmin_en, clr, freeze, alarm
   );

endinterface

// File: rtl/chrono_ctrl_key_repeat.sv
// Auto-repeat for a held set button: after HOLD_TICKS rpt_ticks of continuous hold,
// emits one combinational pulse per further rpt_tick.
module chrono_ctrl_key_repeat #(
   parameter int unsigned HOLD_TICKS = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic lvl,
   input  logic rpt_tick,
   output logic pulse
);

   localparam int unsigned CW = $clog2(HOLD_TICKS + 1);
   localparam logic [CW-1:0] HoldMax = CW'(HOLD_TICKS);

   logic [CW-1:0] cnt_q, cnt_d;

   // Counter saturates at HoldMax; from then on every rpt_tick repeats.
   always_comb begin
      cnt_d = cnt_q;
      pulse = 1'b0;
      if (!en || !lvl) begin
         cnt_d = '0;
      end else if (rpt_tick) begin
         if (cnt_q == HoldMax) begin
            pulse = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/chrono_ctrl.sv
// Sequencer for the shared stopwatch/countdown BCD chain: turns button events and
// ticks into registered count, set, clear, freeze and alarm controls.
module chrono_ctrl
   import chrono_ctrl_pkg::*;
#(
   parameter int unsigned ALARM_SEC  = AlarmSecDefault,
   parameter int unsigned HOLD_TICKS = HoldTicksDefault
) (
   input logic          clk,
   input logic          rst_n,
   chrono_ctrl_if.slave bus
);

   localparam int unsigned AW = $clog2(ALARM_SEC + 1);
   localparam logic [AW-1:0] AlarmLast = AW'(ALARM_SEC - 1);

   state_e        state_q, state_d;
   logic          mode_q;
   logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
   logic          inc_q, inc_d, dec_q, dec_d, sethr_q, sethr_d, setmin_q, setmin_d;
   logic          clr_q, clr_d, freeze_q, freeze_d, alarm_q, alarm_d;
   logic          rpt1, rpt2, in_set;

   assign in_set = (state_q == CSet);

   chrono_ctrl_key_repeat #(.HOLD_TICKS(HOLD_TICKS)) u_rpt1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (in_set),
      .lvl      (bus.btn1_lvl),
      .rpt_tick (bus.rpt_tick),
      .pulse    (rpt1)
   );

   chrono_ctrl_key_repeat #(.HOLD_TICKS(HOLD_TICKS)) u_rpt2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (in_set),
      .lvl      (bus.btn2_lvl),
      .rpt_tick (bus.rpt_tick),
      .pulse    (rpt2)
   );

   // One event per cycle: mode change > set > btn1 > btn2 > sec_tick.
   always_comb begin
      state_d     = state_q;
      alarm_cnt_d = '0;
      alarm_d     = 1'b0;
      inc_d       = 1'b0;
      dec_d       = 1'b0;
      sethr_d     = 1'b0;
      setmin_d    = 1'b0;
      clr_d       = 1'b0;
      if (bus.mode != mode_q) begin
         state_d = bus.mode ? CStop : WStop;
         clr_d   = 1'b1;
      end else begin
         unique case (state_q)
            WStop: begin
               if (bus.btn1_p)      state_d = WRun;
               else if (bus.btn2_p) clr_d = 1'b1;
            end
            WRun, WLap: begin
               if (bus.btn1_p)        state_d = WStop;
               else if (bus.btn2_p)   state_d = (state_q == WRun) ? WLap : WRun;
               else if (bus.sec_tick) inc_d = 1'b1;
            end
            CStop: begin
               if (bus.set)                          state_d = CSet;
               else if (bus.btn1_p && !bus.cnt_zero) state_d = CRun;
            end
            CSet: begin
               if (!bus.set)                 state_d = CStop;
               else if (bus.btn1_p || rpt1)  sethr_d = 1'b1;
               else if (bus.btn2_p || rpt2)  setmin_d = 1'b1;
            end
            CRun, CLap: begin
               if (bus.btn1_p) begin
                  state_d = CStop;
               end else if (bus.btn2_p) begin
                  state_d = (state_q == CRun) ? CLap : CRun;
               end else if (bus.cnt_zero) begin
                  state_d = CDone;
                  alarm_d = 1'b1;
               end else if (bus.sec_tick) begin
                  dec_d = 1'b1;
               end
            end
            CDone: begin
               alarm_d     = alarm_q;
               alarm_cnt_d = alarm_cnt_q;
               if (bus.btn1_p || bus.btn2_p) begin
                  state_d     = CStop;
                  alarm_d     = 1'b0;
                  alarm_cnt_d = '0;
               end else if (bus.sec_tick) begin
                  if (alarm_cnt_q == AlarmLast) begin
                     state_d     = CStop;
                     alarm_d     = 1'b0;
                     alarm_cnt_d = '0;
                  end else begin
                     alarm_cnt_d = alarm_cnt_q + 1'b1;
                     alarm_d     = !alarm_q;
                  end
               end
            end
            default: state_d = WStop;
         endcase
      end
      freeze_d = is_lap(state_d);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= WStop;
         mode_q      <= 1'b0;
         alarm_cnt_q <= '0;
         inc_q       <= 1'b0;
         dec_q       <= 1'b0;
         sethr_q     <= 1'b0;
         setmin_q    <= 1'b0;
         clr_q       <= 1'b0;
         freeze_q    <= 1'b0;
         alarm_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= bus.mode;
         alarm_cnt_q <= alarm_cnt_d;
         inc_q       <= inc_d;
         dec_q       <= dec_d;
         sethr_q     <= sethr_d;
         setmin_q    <= setmin_d;
         clr_q       <= clr_d;
         freeze_q    <= freeze_d;
         alarm_q     <= alarm_d;
      end
   end

   assign bus.state     = state_q;
   assign bus.inc_en    = inc_q;
   assign bus.dec_en    = dec_q;
   assign bus.sethr_en  = sethr_q;
   assign bus.setmin_en = setmin_q;
   assign bus.clr       = clr_q;
   assign bus.freeze    = freeze_q;
   assign bus.alarm     = alarm_q;

endmodule

// File: tb/tb_chrono_ctrl.sv
// Directed bench for chrono_ctrl: a cycle-by-cycle vector table plus sequences for
// auto-repeat, alarm expiry and mid-run reset.
module tb_chrono_ctrl;

   typedef struct {
      string      name;
      logic [5:0] in;   // {mode, set, btn1_p, btn2_p, sec_tick, cnt_zero}
      logic [9:0] exp;  // {state, inc, dec, sethr, setmin, clr, freeze, alarm}
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;
   int   cnt;
   vec_t vecs[$];

   chrono_ctrl_if bus ();

   chrono_ctrl #(.ALARM_SEC(10), .HOLD_TICKS(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [9:0] outs();
      return {bus.state, bus.inc_en, bus.dec_en, bus.sethr_en, bus.setmin_en,
              bus.clr, bus.freeze, bus.alarm};
   endfunction

   function automatic void add(string n, logic [5:0] in, logic [2:0] st, logic [6:0] fl);
      vecs.push_back('{n, in, {st, fl}});
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs set before the call are sampled at the edge; pulse inputs then drop.
   task automatic step();
      @(posedge clk);
      #1;
      bus.btn1_p   = 1'b0;
      bus.btn2_p   = 1'b0;
      bus.sec_tick = 1'b0;
      bus.rpt_tick = 1'b0;
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      {bus.sec_tick, bus.rpt_tick, bus.btn1_p, bus.btn2_p} = '0;
      {bus.btn1_lvl, bus.btn2_lvl, bus.mode, bus.set, bus.cnt_zero} = '0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      check("reset_state", outs(), 10'b000_0000000);

      //   name          m s b1 b2 sec cz   state  inc dec hr mn clr frz alm
      add("idle",       6'b000000, 3'b000, 7'b0000000);
      add("w_start",    6'b001000, 3'b001, 7'b0000000);
      add("w_sec1",     6'b000010, 3'b001, 7'b1000000);
      add("w_idle",     6'b000000, 3'b001, 7'b0000000);
      add("w_sec2",     6'b000010, 3'b001, 7'b1000000);
      add("w_sec3",     6'b000010, 3'b001, 7'b1000000);
      add("w_lap",      6'b000100, 3'b010, 7'b0000010);
      add("lap_sec1",   6'b000010, 3'b010, 7'b1000010);
      add("lap_sec2",   6'b000010, 3'b010, 7'b1000010);
      add("lap_b2_sec", 6'b000110, 3'b001, 7'b0000000);
      add("w_stop",     6'b001000, 3'b000, 7'b0000000);
      add("w_clear",    6'b000100, 3'b000, 7'b0000100);
      add("to_cdown",   6'b100000, 3'b100, 7'b0000100);
      add("c_start_z",  6'b101001, 3'b100, 7'b0000000);
      add("c_start",    6'b101000, 3'b101, 7'b0000000);
      add("c_sec",      6'b100010, 3'b101, 7'b0100000);
      add("c_lap",      6'b100100, 3'b110, 7'b0000010);
      add("clap_sec",   6'b100010, 3'b110, 7'b0100010);
      add("clap_b1sec", 6'b101010, 3'b100, 7'b0000000);
      add("c_start2",   6'b101000, 3'b101, 7'b0000000);
      add("crun_b1sec", 6'b101010, 3'b100, 7'b0000000);
      add("to_watch",   6'b000000, 3'b000, 7'b0000100);
      add("w_set_ign",  6'b011000, 3'b001, 7'b0000000);
      add("mode_set",   6'b110000, 3'b100, 7'b0000100);
      add("c_set",      6'b110000, 3'b011, 7'b0000000);
      add("set_both",   6'b111100, 3'b011, 7'b0010000);
      add("set_min",    6'b110100, 3'b011, 7'b0001000);
      add("set_exit",   6'b100000, 3'b100, 7'b0000000);
      add("c_start3",   6'b101000, 3'b101, 7'b0000000);
      add("c_lap2",     6'b100100, 3'b110, 7'b0000010);
      add("clap_zero",  6'b100011, 3'b111, 7'b0000001);
      add("done_btn",   6'b101001, 3'b100, 7'b0000000);
      add("cstop_b2",   6'b100100, 3'b100, 7'b0000000);

      foreach (vecs[i]) begin
         {bus.mode, bus.set, bus.btn1_p, bus.btn2_p, bus.sec_tick, bus.cnt_zero} = vecs[i].in;
         step();
         check(vecs[i].name, outs(), vecs[i].exp);
      end

      // Held button outside C_SET must never produce set pulses.
      bus.cnt_zero = 1'b0;
      bus.btn1_lvl = 1'b1;
      cnt = 0;
      for (int i = 0; i < 7; i++) begin
         bus.rpt_tick = 1'b1;
         step();
         cnt += int'(bus.sethr_en);
      end
      check("no_rpt_cstop", cnt, 0);
      bus.btn1_lvl = 1'b0;
      bus.set = 1'b1;
      step();
      check("enter_set", bus.state, 3'b011);

      // Press + hold through 8 rpt_ticks: 1 press pulse + 3 repeats.
      bus.btn1_p   = 1'b1;
      bus.btn1_lvl = 1'b1;
      step();
      cnt = int'(bus.sethr_en);
      for (int i = 0; i < 8; i++) begin
         bus.rpt_tick = 1'b1;
         step();
         cnt += int'(bus.sethr_en);
         step();
         cnt += int'(bus.sethr_en);
      end
      check("hr_repeat_cnt", cnt, 4);

      // Release clears the hold count: 5 ticks silent, 6th repeats.
      bus.btn1_lvl = 1'b0;
      step();
      bus.btn1_lvl = 1'b1;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         bus.rpt_tick = 1'b1;
         step();
         cnt += int'(bus.sethr_en);
      end
      check("hr_rehold_quiet", cnt, 0);
      bus.rpt_tick = 1'b1;
      step();
      check("hr_rehold_6th", bus.sethr_en, 1'b1);
      bus.btn1_lvl = 1'b0;
      step();

      bus.btn2_lvl = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         bus.rpt_tick = 1'b1;
         step();
         cnt += int'(bus.setmin_en);
      end
      check("min_repeat_cnt", cnt, 1);
      bus.btn2_lvl = 1'b0;
      bus.set = 1'b0;
      step();
      check("leave_set", bus.state, 3'b100);

      // Expiry: zero with a simultaneous tick gives no dec_en, alarm blinks, auto-return.
      bus.btn1_p = 1'b1;
      step();
      check("alarm_run", bus.state, 3'b101);
      bus.cnt_zero = 1'b1;
      bus.sec_tick = 1'b1;
      step();
      check("alarm_entry", outs(), 10'b111_0000001);
      for (int i = 1; i <= 10; i++) begin
         bus.sec_tick = 1'b1;
         step();
         if (i < 10) check($sformatf("alarm_tick%0d", i), outs(), {3'b111, 6'b0, i % 2 == 0});
         else        check("alarm_expire", outs(), 10'b100_0000000);
         step();
      end

      // Synchronous reset in C_RUN wins over simultaneous events.
      bus.cnt_zero = 1'b0;
      bus.btn1_p   = 1'b1;
      step();
      check("rst_pre_run", bus.state, 3'b101);
      rst_n        = 1'b0;
      bus.sec_tick = 1'b1;
      bus.btn2_p   = 1'b1;
      step();
      check("rst_in_run", outs(), 10'b000_0000000);
      rst_n    = 1'b1;
      bus.mode = 1'b0;
      step();
      check("rst_release", outs(), 10'b000_0000000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
